// File: rtl/ec_datapath_param.sv
// ec_datapath_param
// Parametrised accumulator datapath. It contains a program counter, an
// instruction register, a unified instruction/data RAM, an accumulator A,
// a 4-function ALU and a registered output port. An external control FSM
// drives it one cycle at a time through strobes, and the datapath returns
// status to that FSM.
//
// Instruction format: opcode = IR[DW-1:AW], address = IR[AW-1:0].
//
// Ports
//   Clock, Reset     rising-edge clock, asynchronous active-high reset
//   IRload           IR <= memory read data
//   JMPmux, PCload   PC next source (0 = PC+1, 1 = IR address) and load
//   Meminst          memory address select (0 = PC, 1 = IR address)
//   MemWr            M[addr] <= A
//   Aload, Asel      A <= ALU / Input / memory / hold
//   ALUop            00 add, 01 sub, 10 and, 11 or
//   Outload          Output <= A
//   Input            external data input
//   Aeq0, Apos       combinational status of A
//   C, V             registered carry and signed-overflow flags
//   IR               opcode field of the instruction register
//   PC               program counter (debug)
//   Output           registered output port
module ec_datapath_param #(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             IRload,
    input  logic             JMPmux,
    input  logic             PCload,
    input  logic             Meminst,
    input  logic             MemWr,
    input  logic             Aload,
    input  logic [1:0]       ALUop,
    input  logic [1:0]       Asel,
    input  logic             Outload,
    input  logic [DW-1:0]    Input,
    output logic             Aeq0,
    output logic             Apos,
    output logic             C,
    output logic             V,
    output logic [DW-AW-1:0] IR,
    output logic [AW-1:0]    PC,
    output logic [DW-1:0]    Output
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ir_q;
    logic [DW-1:0] a_q;
    logic [AW-1:0] addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] b_op;
    logic [DW:0]   sum;
    logic [DW-1:0] alu_r;
    logic          alu_v;
    logic [AW-1:0] pc_next;

    assign addr    = Meminst ? ir_q[AW-1:0] : PC;
    assign rd_data = mem[addr];

    // Subtraction reuses the adder as A + ~B + 1, so a carry-out of 1 means
    // no borrow. With B inverted, the add and sub overflow rules collapse
    // into one test: the operands going into the adder share a sign and the
    // result sign differs from it.
    always_comb begin
        b_op  = (ALUop == 2'b01) ? ~rd_data : rd_data;
        sum   = {1'b0, a_q} + {1'b0, b_op} + {{DW{1'b0}}, (ALUop == 2'b01)};
        alu_v = (a_q[DW-1] == b_op[DW-1]) && (sum[DW-1] != a_q[DW-1]);
        alu_r = sum[DW-1:0];
        case (ALUop)
            2'b10:   alu_r = a_q & rd_data;
            2'b11:   alu_r = a_q | rd_data;
            default: alu_r = sum[DW-1:0];
        endcase
    end

    assign pc_next = JMPmux ? ir_q[AW-1:0] : PC + AW'(1);

    // All architectural registers sample pre-edge values, so simultaneous
    // strobes (fetch, store-and-load, output-and-load) behave as if in parallel.
    // Flags change only on ALU loads: arithmetic sets them, logic clears them.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            PC     <= '0;
            ir_q   <= '0;
            a_q    <= '0;
            C      <= 1'b0;
            V      <= 1'b0;
            Output <= '0;
        end else begin
            if (PCload)
                PC <= pc_next;
            if (IRload)
                ir_q <= rd_data;
            if (Outload)
                Output <= a_q;
            if (Aload) begin
                case (Asel)
                    2'b00:   a_q <= alu_r;
                    2'b01:   a_q <= Input;
                    2'b10:   a_q <= rd_data;
                    default: a_q <= a_q;
                endcase
                if (Asel == 2'b00) begin
                    if (!ALUop[1]) begin
                        C <= sum[DW];
                        V <= alu_v;
                    end else begin
                        C <= 1'b0;
                        V <= 1'b0;
                    end
                end
            end
        end
    end

    // RAM contents survive reset; a write is suppressed while reset is held
    // so that reset can never disturb memory.
    always_ff @(posedge Clock) begin
        if (MemWr && !Reset)
            mem[addr] <= a_q;
    end

    assign IR   = ir_q[DW-1:AW];
    assign Aeq0 = (a_q == '0);
    assign Apos = !a_q[DW-1] && (a_q != '0);

endmodule

// File: tb/tb_ec_datapath_param.sv
// tb_ec_datapath_param
// Scoreboard bench for ec_datapath_param. Two instances are driven from
// shared strobes: a narrow one (DW=8, AW=5) and a wide one (DW=16, AW=8).
// Each has its own reset and data input. The instance not under test is
// held in reset. Stimulus pushes the expected register state into a queue,
// and a monitor on the falling edge pops the entries and compares them.
module tb_ec_datapath_param;

    logic        Clock = 1'b0;
    logic        nReset = 1'b1;
    logic        wReset = 1'b1;
    logic        IRload = 1'b0;
    logic        JMPmux = 1'b0;
    logic        PCload = 1'b0;
    logic        Meminst = 1'b0;
    logic        MemWr = 1'b0;
    logic        Aload = 1'b0;
    logic        Outload = 1'b0;
    logic [1:0]  ALUop = 2'b00;
    logic [1:0]  Asel = 2'b00;
    logic [7:0]  nInput = '0;
    logic [15:0] wInput = '0;

    logic        nAeq0, nApos, nC, nV;
    logic [2:0]  nIR;
    logic [4:0]  nPC;
    logic [7:0]  nOutput;
    logic        wAeq0, wApos, wC, wV;
    logic [7:0]  wIR;
    logic [7:0]  wPC;
    logic [15:0] wOutput;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          inst;
        string       name;
        logic [15:0] pc;
        logic [15:0] ir;
        logic [15:0] out;
        logic [15:0] a;
        logic        c;
        logic        v;
    } exp_t;

    exp_t sbq[$];

    logic [15:0] ePc, eIr, eOut, eA;
    logic        eC, eV;

    ec_datapath_param #(.DW(8), .AW(5)) dutNarrow (
        .Clock(Clock), .Reset(nReset), .IRload(IRload), .JMPmux(JMPmux),
        .PCload(PCload), .Meminst(Meminst), .MemWr(MemWr), .Aload(Aload),
        .ALUop(ALUop), .Asel(Asel), .Outload(Outload), .Input(nInput),
        .Aeq0(nAeq0), .Apos(nApos), .C(nC), .V(nV), .IR(nIR), .PC(nPC),
        .Output(nOutput)
    );

    ec_datapath_param #(.DW(16), .AW(8)) dutWide (
        .Clock(Clock), .Reset(wReset), .IRload(IRload), .JMPmux(JMPmux),
        .PCload(PCload), .Meminst(Meminst), .MemWr(MemWr), .Aload(Aload),
        .ALUop(ALUop), .Asel(Asel), .Outload(Outload), .Input(wInput),
        .Aeq0(wAeq0), .Apos(wApos), .C(wC), .V(wV), .IR(wIR), .PC(wPC),
        .Output(wOutput)
    );

    always #5 Clock = ~Clock;

    // Drive one cycle of strobes, let the rising edge take them, then drop
    // every strobe back to idle.
    task automatic applyStimulus(input bit irl, input bit jmp, input bit pcl,
                                 input bit mi, input bit mw, input bit al,
                                 input logic [1:0] op, input logic [1:0] sel,
                                 input bit ol, input logic [15:0] din);
        IRload  = irl;
        JMPmux  = jmp;
        PCload  = pcl;
        Meminst = mi;
        MemWr   = mw;
        Aload   = al;
        ALUop   = op;
        Asel    = sel;
        Outload = ol;
        nInput  = din[7:0];
        wInput  = din;
        @(posedge Clock);
        #1;
        IRload  = 1'b0;
        JMPmux  = 1'b0;
        PCload  = 1'b0;
        Meminst = 1'b0;
        MemWr   = 1'b0;
        Aload   = 1'b0;
        ALUop   = 2'b00;
        Asel    = 2'b00;
        Outload = 1'b0;
    endtask

    // Queue the currently expected state of one instance for the monitor.
    task automatic checkOutput(input int inst, input string name);
        exp_t e;
        e.inst = inst;
        e.name = name;
        e.pc   = ePc;
        e.ir   = eIr;
        e.out  = eOut;
        e.a    = eA;
        e.c    = eC;
        e.v    = eV;
        sbq.push_back(e);
    endtask

    task automatic clearExpected();
        ePc  = '0;
        eIr  = '0;
        eOut = '0;
        eA   = '0;
        eC   = 1'b0;
        eV   = 1'b0;
    endtask

    task automatic compare(input string name, input string field,
                           input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s actual=%h required=%h", name, field, act, exp);
        end
    endtask

    // Monitor: on each falling edge, drain the scoreboard against the
    // instance each entry names.
    initial begin : monitor
        exp_t        e;
        logic [15:0] aPc, aIr, aOut;
        logic        aAeq, aApos, aC, aV, xAeq, xApos;
        forever begin
            @(negedge Clock);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.inst == 0) begin
                    aPc   = {11'b0, nPC};
                    aIr   = {13'b0, nIR};
                    aOut  = {8'b0, nOutput};
                    aAeq  = nAeq0;
                    aApos = nApos;
                    aC    = nC;
                    aV    = nV;
                    xAeq  = (e.a[7:0] == 8'h00);
                    xApos = !e.a[7] && (e.a[7:0] != 8'h00);
                end else begin
                    aPc   = {8'b0, wPC};
                    aIr   = {8'b0, wIR};
                    aOut  = wOutput;
                    aAeq  = wAeq0;
                    aApos = wApos;
                    aC    = wC;
                    aV    = wV;
                    xAeq  = (e.a == 16'h0000);
                    xApos = !e.a[15] && (e.a != 16'h0000);
                end
                compare(e.name, "PC", aPc, e.pc);
                compare(e.name, "IR", aIr, e.ir);
                compare(e.name, "Output", aOut, e.out);
                compare(e.name, "C", {15'b0, aC}, {15'b0, e.c});
                compare(e.name, "V", {15'b0, aV}, {15'b0, e.v});
                compare(e.name, "Aeq0", {15'b0, aAeq}, {15'b0, xAeq});
                compare(e.name, "Apos", {15'b0, aApos}, {15'b0, xApos});
            end
        end
    end

    initial begin : stimulus
        clearExpected();

        // Reset with random strobes active, then release with strobes idle.
        IRload  = 1'($urandom);
        JMPmux  = 1'($urandom);
        PCload  = 1'($urandom);
        Meminst = 1'($urandom);
        MemWr   = 1'($urandom);
        Aload   = 1'($urandom);
        Outload = 1'($urandom);
        ALUop   = 2'($urandom);
        Asel    = 2'($urandom);
        nInput  = 8'($urandom);
        wInput  = 16'($urandom);
        repeat (2) @(posedge Clock);
        #1;
        checkOutput(0, "rst_hold");
        @(negedge Clock);
        applyStimulus(0,0,0,0,0,0,2'b00,2'b00,0,16'h0000);
        @(negedge Clock);
        nReset = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        checkOutput(0, "rst_release");

        // Load and fetch.
        applyStimulus(0,0,0,0,0,1,2'b00,2'b01,0,16'h0023); eA = 16'h23;
        checkOutput(0, "load_input");
        applyStimulus(0,0,0,0,1,0,2'b00,2'b00,0,16'h0000);
        checkOutput(0, "store_m0");
        applyStimulus(1,0,1,0,0,0,2'b00,2'b00,0,16'h0000); eIr = 16'h1; ePc = 16'h1;
        checkOutput(0, "fetch");

        // Add with signed overflow: 70 + 70 = E0.
        applyStimulus(0,0,0,0,0,1,2'b00,2'b01,0,16'h0070); eA = 16'h70;
        applyStimulus(0,0,0,1,1,0,2'b00,2'b00,0,16'h0000);
        applyStimulus(0,0,0,1,0,1,2'b00,2'b00,0,16'h0000); eA = 16'hE0; eC = 1'b0; eV = 1'b1;
        checkOutput(0, "add_ovf");
        applyStimulus(0,0,0,0,0,0,2'b00,2'b00,1,16'h0000); eOut = 16'hE0;
        checkOutput(0, "out_add");

        // Subtract to zero: 05 - 05 gives no borrow.
        applyStimulus(0,0,0,0,0,1,2'b00,2'b01,0,16'h0005); eA = 16'h05;
        applyStimulus(0,0,0,1,1,0,2'b00,2'b00,0,16'h0000);
        applyStimulus(0,0,0,1,0,1,2'b01,2'b00,0,16'h0000); eA = 16'h00; eC = 1'b1; eV = 1'b0;
        checkOutput(0, "sub_zero");

        // AND clears the flags: F0 & 3C = 30.
        applyStimulus(0,0,0,0,0,1,2'b00,2'b01,0,16'h003C); eA = 16'h3C;
        applyStimulus(0,0,0,1,1,0,2'b00,2'b00,0,16'h0000);
        applyStimulus(0,0,0,0,0,1,2'b00,2'b01,0,16'h00F0); eA = 16'hF0;
        checkOutput(0, "flags_hold");
        applyStimulus(0,0,0,1,0,1,2'b10,2'b00,0,16'h0000); eA = 16'h30; eC = 1'b0; eV = 1'b0;
        checkOutput(0, "and");

        // Outload together with Aload captures the old A.
        applyStimulus(0,0,0,0,0,1,2'b00,2'b01,1,16'h0055); eOut = 16'h30; eA = 16'h55;
        checkOutput(0, "out_old_a");

        // Asel=11 holds A and the flags even with an add selected (55+3C would overflow).
        applyStimulus(0,0,0,1,0,1,2'b00,2'b11,0,16'h0000);
        checkOutput(0, "asel_hold");

        // MemWr together with Aload stores the old A.
        applyStimulus(0,0,0,1,1,1,2'b00,2'b01,0,16'h0011); eA = 16'h11;
        applyStimulus(0,0,0,1,0,1,2'b00,2'b10,0,16'h0000); eA = 16'h55;
        applyStimulus(0,0,0,0,0,0,2'b00,2'b00,1,16'h0000); eOut = 16'h55;
        checkOutput(0, "mem_old_a");

        // Jump to 1F, then fetch wraps the PC to 0.
        applyStimulus(0,0,0,0,0,1,2'b00,2'b01,0,16'h00FF); eA = 16'hFF;
        applyStimulus(0,0,0,0,1,0,2'b00,2'b00,0,16'h0000);
        applyStimulus(1,0,1,0,0,0,2'b00,2'b00,0,16'h0000); eIr = 16'h7; ePc = 16'h2;
        checkOutput(0, "fetch2");
        applyStimulus(0,0,0,1,1,0,2'b00,2'b00,0,16'h0000);
        applyStimulus(0,1,1,0,0,0,2'b00,2'b00,0,16'h0000); ePc = 16'h1F;
        checkOutput(0, "jump");
        applyStimulus(1,0,1,0,0,0,2'b00,2'b00,0,16'h0000); eIr = 16'h7; ePc = 16'h0;
        checkOutput(0, "wrap");
        applyStimulus(0,1,0,0,0,0,2'b00,2'b00,0,16'h0000);
        checkOutput(0, "jmp_no_load");

        // Read during write returns the old word (M[0]=23); the new one follows.
        applyStimulus(1,0,0,0,1,0,2'b00,2'b00,0,16'h0000); eIr = 16'h1;
        checkOutput(0, "rdw_old");
        applyStimulus(1,0,0,0,0,0,2'b00,2'b00,0,16'h0000); eIr = 16'h7;
        checkOutput(0, "rdw_new");

        // Mid-run reset clears everything.
        @(negedge Clock);
        nReset = 1'b1;
        #1;
        clearExpected();
        checkOutput(0, "rst_again");
        @(negedge Clock);
        @(negedge Clock);

        // Wide configuration.
        wReset = 1'b0;
        applyStimulus(0,0,0,0,0,1,2'b00,2'b01,0,16'h0001); eA = 16'h0001;
        applyStimulus(0,0,0,0,1,0,2'b00,2'b00,0,16'h0000);
        applyStimulus(0,0,0,0,0,1,2'b00,2'b01,0,16'hFFFF); eA = 16'hFFFF;
        applyStimulus(0,0,0,0,0,0,2'b00,2'b00,1,16'h0000); eOut = 16'hFFFF;
        checkOutput(1, "w_out_ffff");
        applyStimulus(0,0,0,0,0,1,2'b00,2'b00,0,16'h0000); eA = 16'h0000; eC = 1'b1; eV = 1'b0;
        checkOutput(1, "w_add_carry");
        applyStimulus(0,0,0,0,0,0,2'b00,2'b00,1,16'h0000); eOut = 16'h0000;
        checkOutput(1, "w_out_zero");
        applyStimulus(0,0,0,0,0,1,2'b00,2'b01,0,16'h00FF); eA = 16'h00FF;
        applyStimulus(0,0,0,0,1,0,2'b00,2'b00,0,16'h0000);
        applyStimulus(1,0,0,0,0,0,2'b00,2'b00,0,16'h0000); eIr = 16'h0000;
        applyStimulus(0,0,0,0,0,1,2'b00,2'b01,0,16'h1234); eA = 16'h1234;
        applyStimulus(0,0,0,1,1,0,2'b00,2'b00,0,16'h0000);
        applyStimulus(0,0,0,0,0,1,2'b00,2'b01,0,16'h0000); eA = 16'h0000;
        applyStimulus(0,0,0,1,0,1,2'b00,2'b10,0,16'h0000); eA = 16'h1234;
        applyStimulus(0,0,0,0,0,0,2'b00,2'b00,1,16'h0000); eOut = 16'h1234;
        checkOutput(1, "w_readback");

        @(negedge Clock);
        @(negedge Clock);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ec_datapath_param.md
Name: ec_datapath_param

Overview:
- Parametrised successor of the 8-bit accumulator datapath: PC, IR, unified instruction/data RAM, accumulator A, ALU, registered output port.
- Driven cycle-by-cycle by an external control FSM through control strobes. Status (Aeq0, Apos, C, V, IR opcode) is returned to that FSM.
- New over the previous generation: configurable data and address widths, a 4-function ALU, sticky-free carry/overflow flags, a registered Output with its own load strobe, and a PC debug output.

Parameters:
- DW, 8: data and instruction word width.
- AW, 5: address width. Memory depth is 2**AW words. Constraint: 1 <= AW < DW.
- The instruction format is opcode = IR[DW-1:AW] and address = IR[AW-1:0].

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- IRload  in  1  IR <= mem read data
- JMPmux  in  1  PC next source: 0 = PC+1, 1 = IR[AW-1:0]
- PCload  in  1  PC <= selected next value
- Meminst  in  1  memory address select: 0 = PC, 1 = IR[AW-1:0]
- MemWr  in  1  M[addr] <= A at the clock edge
- Aload  in  1  A <= Asel-selected value
- ALUop  in  2  00 add, 01 sub, 10 and, 11 or
- Asel  in  2  00 ALU result, 01 Input, 10 mem read data, 11 hold
- Outload  in  1  Output <= A
- Input  in  DW  external data input
- Aeq0  out  1  A == 0 (combinational)
- Apos  out  1  A[DW-1]==0 and A != 0 (strictly positive, combinational)
- C  out  1  carry flag (registered)
- V  out  1  signed overflow flag (registered)
- IR  out  DW-AW  opcode field of the IR register
- PC  out  AW  program counter (debug)
- Output  out  DW  registered output port

Behaviour:
- Reset (async, dominates every other input): PC, IR, A, C, V and Output all go to 0, so Aeq0=1 and Apos=0. RAM contents are not reset.
- Memory:
  - addr = Meminst ? IR[AW-1:0] : PC.
  - Read is asynchronous (combinational).
  - Write is synchronous on MemWr with data A.
  - In a cycle with both read and write to the same address, the read shows the old contents. The new value is visible after the edge.
- ALU, with operand B = mem read data:
  - add: {C,R} = A + B.
  - sub: {C,R} = A + ~B + 1, so C=1 means no borrow.
  - and / or: bitwise.
  - V for add = (A[msb]==B[msb]) && (R[msb]!=A[msb]).
  - V for sub = (A[msb]!=B[msb]) && (R[msb]!=A[msb]).
- Flags update only on an edge where Aload=1, Asel=00 and ALUop is add or sub.
  - An and/or load with Asel=00 clears C and V.
  - All other cycles hold C and V.
- Asel=11 with Aload=1 leaves A unchanged. Flags hold.
- PC: on PCload, PC <= JMPmux ? IR[AW-1:0] : PC+1, modulo 2**AW. 2**AW-1 wraps to 0. With PCload=0, PC holds regardless of JMPmux.
- Conditional jumps are resolved by the controller by gating PCload with Aeq0/Apos. The datapath does not gate.
- IRload: IR <= mem[addr]. The controller keeps Meminst=0 during fetch.
- Simultaneous strobes are legal. All registers sample pre-edge values:
  - IRload+PCload (fetch): IR gets M[old PC], PC gets old PC+1.
  - MemWr+Aload: memory gets the old A.
  - Outload+Aload: Output gets the old A.
- Latency: every register updates on the edge that samples its strobe. Status outputs reflect the new A in the same cycle after that edge.
- Reset asserted mid-operation, e.g. during a write cycle: registers clear immediately. Whether the pending write lands depends on whether the edge occurred first; reset never corrupts other addresses.

Test Plan:
1. Assert Reset with random strobes active -> PC=0, IR=0, Output=0, C=V=0, Aeq0=1, Apos=0. Release Reset -> all hold with strobes low.
2. Load and fetch (DW=8, AW=5):
   - Input=8'h23, Aload with Asel=01 -> A=23.
   - MemWr with Meminst=0 -> M[0]=23.
   - IRload+PCload with JMPmux=0 -> IR=3'b001, PC=1, Apos=1.
3. Add with overflow: M[3]=8'h70, A=8'h70, Aload with Asel=00, ALUop=00, Meminst=1 -> A=E0, C=0, V=1, Apos=0, Aeq0=0.
4. Subtract and logic:
   - A=05, M[3]=05, sub -> A=00, C=1, V=0, Aeq0=1.
   - Then A=F0, M[3]=3C, and -> A=30, C=0, V=0.
5. Jump and wrap:
   - IR addr=5'h1F, JMPmux=1, PCload -> PC=1F.
   - Fetch (JMPmux=0) -> PC=00.
   - JMPmux=1 with PCload=0 -> PC unchanged.
6. Wide configuration (DW=16, AW=8): A=FFFF, M[n]=0001, add -> A=0000, C=1, V=0, Aeq0=1. Then Outload -> Output=0000, and A=1234 written to M[FF] reads back 1234.
